// File: rtl/irda_sir_tx.sv
// ---------------------------------------------------------------------------
// irda_sir_tx
//
// IrDA SIR transmitter for the iCEstick IR transceiver. Bytes arrive on a
// valid/ready port and are framed UART-style (start bit, 8 data bits LSB
// first, stop bit). Each bit cell is BIT_CLKS clocks long. A 0 cell is sent
// as a PULSE_CLKS-wide high pulse at the start of the cell. A 1 cell keeps
// the line low. A one-entry holding register lets the producer queue the
// next byte while the current frame is still on the wire, so frames can run
// back to back with no gap.
//
// Ports:
//   CLK         system clock (12 MHz on the iCEstick)
//   RST         synchronous, active-high reset; aborts any frame in flight
//   data_in     byte to transmit, captured when data_valid && data_ready
//   data_valid  producer has a byte on data_in
//   data_ready  holding register is empty (held low during reset)
//   irda_txd    registered drive for the IR transceiver TXD pin
//   busy        a frame is being sent or a byte is waiting in the hold
// ---------------------------------------------------------------------------
module irda_sir_tx #(
    parameter int BIT_CLKS   = 104,
    parameter int PULSE_CLKS = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       irda_txd,
    output logic       busy
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] CELL_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CLKS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cell_cnt;
    logic [CW-1:0] cell_cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shifter;
    logic [7:0]    shifter_next;
    logic [7:0]    hold;
    logic          hold_full;
    logic          hold_drain;
    logic          transfer;
    logic          cell_end;
    logic          cell_val;
    logic          txd_next;

    // The hold can only be refilled when it is empty, so a transfer and a
    // drain never coincide. Reset forces data_ready low so nothing is
    // accepted on the reset edge itself.
    assign data_ready = !hold_full && !RST;
    assign transfer   = data_valid && data_ready;
    assign busy       = (state != IDLE) || hold_full;
    assign cell_end   = (cell_cnt == CELL_LAST);

    // Logical value of the cell currently being sent. IDLE behaves like a
    // 1 cell so the line stays quiet between frames.
    always_comb begin
        cell_val = 1'b1;
        case (state)
            START:   cell_val = 1'b0;
            DATA:    cell_val = shifter[bit_idx];
            default: cell_val = 1'b1;
        endcase
    end

    // RZI encoding: a 0 cell drives a pulse for the first PULSE_CLKS clocks
    // of the cell. This is registered below, so the pin lags the counter by
    // one clock, which is what gives the two-cycle start latency.
    assign txd_next = !cell_val && (cell_cnt < PULSE_END);

    // Next-state logic. Every non-idle state spends exactly BIT_CLKS clocks
    // per cell. Leaving STOP with a byte already held jumps straight into
    // START so consecutive frames are exactly 10 cells apart.
    always_comb begin
        state_next    = state;
        cell_cnt_next = cell_cnt;
        bit_idx_next  = bit_idx;
        shifter_next  = shifter;
        hold_drain    = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    hold_drain    = 1'b1;
                    shifter_next  = hold;
                    cell_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = START;
                end
            end

            START: begin
                if (cell_end) begin
                    cell_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = DATA;
                end else begin
                    cell_cnt_next = cell_cnt + CW'(1);
                end
            end

            DATA: begin
                if (cell_end) begin
                    cell_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = 3'd0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cell_cnt_next = cell_cnt + CW'(1);
                end
            end

            STOP: begin
                if (cell_end) begin
                    cell_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    if (hold_full) begin
                        hold_drain   = 1'b1;
                        shifter_next = hold;
                        state_next   = START;
                    end else begin
                        state_next   = IDLE;
                    end
                end else begin
                    cell_cnt_next = cell_cnt + CW'(1);
                end
            end

            default: begin
                cell_cnt_next = '0;
                bit_idx_next  = 3'd0;
                state_next    = IDLE;
            end
        endcase
    end

    // State, counters, shifter, holding register and the TXD flop. Reset
    // drops everything, including a held byte, so an interrupted frame never
    // resumes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cell_cnt  <= '0;
            bit_idx   <= 3'd0;
            shifter   <= 8'h00;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            irda_txd  <= 1'b0;
        end else begin
            state    <= state_next;
            cell_cnt <= cell_cnt_next;
            bit_idx  <= bit_idx_next;
            shifter  <= shifter_next;
            irda_txd <= txd_next;
            if (transfer) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (hold_drain) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irda_sir_tx.sv
// ---------------------------------------------------------------------------
// tb_irda_sir_tx
//
// Self-checking bench for irda_sir_tx. Stimulus pushes the byte it hands
// over (and the expected spacing from the previous frame) into a queue. An
// independent monitor watches irda_txd, slices each frame into bit cells,
// decodes the byte from the pulse pattern and compares it against the queue.
// Latency, pulse width, busy timing, reset and idle behaviour are checked
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_irda_sir_tx;

    localparam int B = 104;
    localparam int P = 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       irda_txd;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t expQ[$];

    int checks     = 0;
    int failures   = 0;
    int cycle      = 0;
    int resetCount = 0;
    int lastStart  = 0;

    irda_sir_tx #(
        .BIT_CLKS   (B),
        .PULSE_CLKS (P)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .irda_txd   (irda_txd),
        .busy       (busy)
    );

    // Free-running 100 MHz-style bench clock; only the cycle count matters.
    always #5 CLK = ~CLK;

    // Cycle counter for gap measurements, plus a count of reset edges so the
    // monitor can tell that a frame it was collecting has been aborted.
    always @(posedge CLK) begin
        cycle <= cycle + 1;
        if (RST) resetCount <= resetCount + 1;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycle);
        end
    endtask

    // Offer one byte, wait (bounded) for data_ready, record the expected
    // frame, and return at the negedge after the transfer edge with
    // data_valid still high. With scramble set, data_in changes every cycle
    // while the DUT is not ready, and the value present when ready rises is
    // the one that must come out.
    task automatic applyStimulus(input logic [7:0] d, input int gap, input bit scramble);
        int n;
        n = 0;
        data_in    = d;
        data_valid = 1'b1;
        while (!data_ready && n < 4 * 10 * B) begin
            @(negedge CLK);
            n++;
            if (scramble) data_in = d ^ 8'(n * 37);
        end
        checkOutput("ready_timeout", int'(data_ready), 1);
        expQ.push_back('{data_in, gap});
        @(negedge CLK);
        checkOutput("ready_drop", int'(data_ready), 0);
    endtask

    // Called at the negedge after a transfer into an idle DUT: the pin must
    // stay low one more cycle, then pulse for exactly P cycles.
    task automatic checkLatency();
        @(negedge CLK);
        checkOutput("latency_k1_txd", int'(irda_txd), 0);
        checkOutput("latency_k1_busy", int'(busy), 1);
        @(negedge CLK);
        checkOutput("latency_k2_txd", int'(irda_txd), 1);
        repeat (P - 1) @(negedge CLK);
        checkOutput("pulse_last_cycle", int'(irda_txd), 1);
        @(negedge CLK);
        checkOutput("pulse_after_end", int'(irda_txd), 0);
    endtask

    // Wait (bounded) until every expected frame has been seen and the DUT
    // has gone idle.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 30 * B) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("drain_timeout", (expQ.size() == 0 && !busy) ? 1 : 0, 1);
        repeat (3) @(negedge CLK);
    endtask

    // Monitor: a frame starts on the first high sample of irda_txd. The next
    // 10*B samples are binned into cells; a cell with no high samples is a 1,
    // a cell whose pulse is exactly P wide at the cell start is a 0. Frames
    // cut short by reset are dropped without popping the queue.
    initial begin : monitor
        int         hc[10];
        int         startCycle;
        int         rc;
        bit         shapeBad;
        bit         aborted;
        logic [7:0] dec;
        exp_t       e;
        forever begin
            do @(negedge CLK); while (irda_txd !== 1'b1);
            startCycle = cycle;
            rc         = resetCount;
            shapeBad   = 1'b0;
            aborted    = 1'b0;
            for (int c = 0; c < 10; c++) hc[c] = 0;
            for (int s = 0; s < 10 * B; s++) begin
                if (s > 0) @(negedge CLK);
                if (resetCount != rc) begin
                    aborted = 1'b1;
                    break;
                end
                if (irda_txd === 1'b1) begin
                    hc[s / B]++;
                    if ((s % B) >= P) shapeBad = 1'b1;
                end
            end
            if (!aborted) begin
                for (int c = 0; c < 10; c++)
                    if (hc[c] != 0 && hc[c] != P) shapeBad = 1'b1;
                for (int i = 0; i < 8; i++) dec[i] = (hc[i + 1] == 0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame: got byte 0x%0h, expected no frame at cycle %0d",
                             dec, cycle);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("frame_data", int'(dec), int'(e.data));
                    checkOutput("start_pulse_width", hc[0], P);
                    checkOutput("stop_cell_pulse", hc[9], 0);
                    checkOutput("pulse_shape_bad", int'(shapeBad), 0);
                    if (e.gap >= 0) checkOutput("frame_gap", startCycle - lastStart, e.gap);
                end
                lastStart = startCycle;
            end
        end
    end

    // Directed test sequence.
    initial begin : stimulus
        int bad;
        RST        = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        checkOutput("reset_txd", int'(irda_txd), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ready", int'(data_ready), 0);
        RST = 1'b0;
        #1;
        checkOutput("ready_after_reset", int'(data_ready), 1);

        // Idle line
        bad = 0;
        repeat (5000) begin
            @(negedge CLK);
            if (irda_txd !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) bad++;
        end
        checkOutput("idle_line_violations", bad, 0);

        // Single 0x55: latency, pulse width and busy falling 10 cells after START
        applyStimulus(8'h55, -1, 1'b0);
        data_valid = 1'b0;
        checkLatency();
        repeat (10 * B - 2 - P) @(negedge CLK);
        checkOutput("busy_before_end", int'(busy), 1);
        @(negedge CLK);
        checkOutput("busy_at_end", int'(busy), 0);
        waitDrain();

        // All-ones and all-zeros bytes
        applyStimulus(8'hFF, -1, 1'b0);
        data_valid = 1'b0;
        waitDrain();
        applyStimulus(8'h00, -1, 1'b0);
        data_valid = 1'b0;
        waitDrain();

        // Back-to-back stream with data_valid held high
        applyStimulus(8'hA5, -1, 1'b0);
        applyStimulus(8'h3C, 10 * B, 1'b0);
        applyStimulus(8'h81, 10 * B, 1'b0);
        data_valid = 1'b0;
        waitDrain();

        // data_in churning while data_ready is low
        applyStimulus(8'h11, -1, 1'b0);
        applyStimulus(8'h22, 10 * B, 1'b0);
        applyStimulus(8'h77, 10 * B, 1'b1);
        data_valid = 1'b0;
        waitDrain();

        // Reset mid-DATA with a byte held
        applyStimulus(8'h5A, -1, 1'b0);
        applyStimulus(8'hC3, 10 * B, 1'b0);
        data_valid = 1'b0;
        repeat (300) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("midreset_txd", int'(irda_txd), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        RST = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset_ready", int'(data_ready), 1);
        bad = 0;
        repeat (200) begin
            @(negedge CLK);
            if (irda_txd !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("post_reset_quiet", bad, 0);
        applyStimulus(8'hE7, -1, 1'b0);
        data_valid = 1'b0;
        checkLatency();
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
